// File: rtl/rf_alu_pkg.sv
// Shared types and default widths for the rf_alu_seq sequencer and its alu8 datapath.
package rf_alu_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int ADDR_W_DEFAULT = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_LDI = 3'd6,
    OP_SHL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rf_alu_seq_alu8.sv
// Combinational ALU for the sequencer. Define RF_ALU_SAT_EN to make ADD/SUB
// saturate instead of wrapping; carry always reports the raw overflow/borrow.
module alu8
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] and_bits;
  logic [DATA_W-1:0] or_bits;
  logic [DATA_W-1:0] xor_bits;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  // The extra MSB of the widened difference is the borrow (a < b).
  assign diff_ext = {1'b0, a} - {1'b0, b};

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_logic
    assign and_bits[gi] = a[gi] & b[gi];
    assign or_bits[gi]  = a[gi] | b[gi];
    assign xor_bits[gi] = a[gi] ^ b[gi];
  end

`ifdef RF_ALU_SAT_EN
  assign add_res = sum_ext[DATA_W]  ? {DATA_W{1'b1}} : sum_ext[DATA_W-1:0];
  assign sub_res = diff_ext[DATA_W] ? {DATA_W{1'b0}} : diff_ext[DATA_W-1:0];
`else
  assign add_res = sum_ext[DATA_W-1:0];
  assign sub_res = diff_ext[DATA_W-1:0];
`endif

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = add_res;
        carry  = sum_ext[DATA_W];
      end
      OP_SUB: begin
        result = sub_res;
        carry  = diff_ext[DATA_W];
      end
      OP_AND: result = and_bits;
      OP_OR:  result = or_bits;
      OP_XOR: result = xor_bits;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_alu_seq.sv
// Single-issue ALU sequencer driving a 4-entry register file: IDLE -> READ -> EXEC -> WRITE.
// Optional saturating ADD/SUB via RF_ALU_SAT_EN (implemented in alu8).
module rf_alu_seq
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_srca,
  input  logic [ADDR_W-1:0] instr_srcb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_rda_addr,
  output logic [ADDR_W-1:0] rf_rdb_addr,
  input  logic [DATA_W-1:0] rf_rda_data,
  input  logic [DATA_W-1:0] rf_rdb_data,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  seq_state_e        state_reg;
  alu_op_e           op_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  alu8 #(.DATA_W(DATA_W)) u_alu (
    .op     (op_reg),
    .a      (rf_rda_data),
    .b      (rf_rdb_data),
    .imm    (imm_reg),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Read addresses are loaded at the handshake so they are stable for all of
  // READ and EXEC; read data is sampled at the end of EXEC, which covers both
  // combinational and one-cycle-registered register-file reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      instr_ready <= 1'b0;
      op_reg      <= OP_ADD;
      dst_reg     <= '0;
      imm_reg     <= '0;
      rf_rda_addr <= '0;
      rf_rdb_addr <= '0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      rf_wr_en    <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (instr_ready && instr_valid) begin
            op_reg      <= alu_op_e'(instr_op);
            dst_reg     <= instr_dst;
            imm_reg     <= instr_imm;
            rf_rda_addr <= instr_srca;
            rf_rdb_addr <= instr_srcb;
            instr_ready <= 1'b0;
            state_reg   <= ST_READ;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        ST_READ: begin
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          rf_wr_addr <= dst_reg;
          rf_wr_data <= alu_result;
          rf_wr_en   <= 1'b1;
          done       <= 1'b1;
          result     <= alu_result;
          carry      <= alu_carry;
          state_reg  <= ST_WRITE;
        end
        ST_WRITE: begin
          rf_wr_en    <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state_reg   <= ST_IDLE;
        end
        default: begin
          rf_wr_en    <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_alu_seq.sv
// Self-checking bench for rf_alu_seq: directed steps plus random instructions
// checked against an arithmetic reference model of the instruction set.
module tb_rf_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_dst;
  logic [1:0] instr_srca;
  logic [1:0] instr_srcb;
  logic [7:0] instr_imm;
  logic [1:0] rf_rda_addr;
  logic [1:0] rf_rdb_addr;
  logic [7:0] rf_rda_data;
  logic [7:0] rf_rdb_data;
  logic [1:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       done;
  logic [7:0] result;
  logic       carry;

  int errors = 0;
  int checks = 0;

`ifdef RF_ALU_SAT_EN
  localparam logic [7:0] EXP_OVF = 8'hFF;
  localparam logic [7:0] EXP_UNF = 8'h00;
`else
  localparam logic [7:0] EXP_OVF = 8'h10;
  localparam logic [7:0] EXP_UNF = 8'hFC;
`endif

  rf_alu_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_dst   (instr_dst),
    .instr_srca  (instr_srca),
    .instr_srcb  (instr_srcb),
    .instr_imm   (instr_imm),
    .rf_rda_addr (rf_rda_addr),
    .rf_rdb_addr (rf_rdb_addr),
    .rf_rda_data (rf_rda_data),
    .rf_rdb_data (rf_rdb_data),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_wr_en    (rf_wr_en),
    .done        (done),
    .result      (result),
    .carry       (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file: combinational read, write on rising edge.
  logic [7:0] rf_mem [4];
  logic       rf_clear;
  assign rf_rda_data = rf_mem[rf_rda_addr];
  assign rf_rdb_data = rf_mem[rf_rdb_addr];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end

  // Reference architectural state.
  logic [7:0] ref_rf [4];

  function automatic void ref_op(input int op, input int a, input int b, input int imm,
                                 output logic [7:0] r, output logic c);
    int v;
    c = 1'b0;
    v = 0;
    case (op)
      0: begin
        v = a + b;
        c = (v > 255);
`ifdef RF_ALU_SAT_EN
        if (c) v = 255;
`endif
      end
      1: begin
        v = a - b;
        c = (a < b);
        if (v < 0) v = v + 256;
`ifdef RF_ALU_SAT_EN
        if (c) v = 0;
`endif
      end
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      5: v = a;
      6: v = imm;
      default: begin
        v = (a * 2) % 256;
        c = (a > 127);
      end
    endcase
    r = v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a falling edge; returns at a falling edge with instr_ready high.
  task automatic wait_ready();
    int t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) check("ready_timeout", {31'b0, instr_ready}, 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [7:0] imm);
    int n;
    logic [7:0] er;
    logic ec;
    wait_ready();
    ref_op(int'(op), int'(ref_rf[sa]), int'(ref_rf[sb]), int'(imm), er, ec);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dst   = dst;
    instr_srca  = sa;
    instr_srcb  = sb;
    instr_imm   = imm;
    @(negedge clk);
    n = 1;
    // Scramble the inputs mid-operation; they must be ignored.
    instr_valid = 1'b0;
    instr_op    = 3'($urandom);
    instr_dst   = 2'($urandom);
    instr_srca  = 2'($urandom);
    instr_srcb  = 2'($urandom);
    instr_imm   = 8'($urandom);
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 3);
    check("wr_en", {31'b0, rf_wr_en}, 32'd1);
    check("wr_addr", {30'b0, rf_wr_addr}, {30'b0, dst});
    check("wr_data", {24'b0, rf_wr_data}, {24'b0, er});
    check("result", {24'b0, result}, {24'b0, er});
    check("carry", {31'b0, carry}, {31'b0, ec});
    $display("op=%0d dst=%0d a=%02h b=%02h imm=%02h -> res=%02h carry=%0d (exp %02h/%0d)",
             op, dst, ref_rf[sa], ref_rf[sb], imm, result, carry, er, ec);
    ref_rf[dst] = er;
    @(negedge clk);
    check("done_width", {31'b0, done}, 32'd0);
    check("result_hold", {24'b0, result}, {24'b0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cyc [3];
    int d_cyc [3];
    int k;
    int nd;
    int wr_cnt;
    logic [2:0] h_op [3];
    logic [1:0] h_dst [3];
    logic [1:0] h_sa [3];
    logic [1:0] h_sb [3];
    logic [7:0] h_imm [3];
    logic [7:0] er;
    logic ec;

    rst_n       = 1'b0;
    rf_clear    = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_dst   = 2'd0;
    instr_srca  = 2'd0;
    instr_srcb  = 2'd0;
    instr_imm   = 8'd0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;

    // Reset for 5 cycles: all outputs zero.
    repeat (5) @(negedge clk);
    rf_clear = 1'b0;
    check("rst_ready", {31'b0, instr_ready}, 32'd0);
    check("rst_wr_en", {31'b0, rf_wr_en}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_carry", {31'b0, carry}, 32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_wr_data", {24'b0, rf_wr_data}, 32'd0);
    check("rst_addrs", {26'b0, rf_rda_addr, rf_rdb_addr, rf_wr_addr}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'b0, instr_ready}, 32'd1);

    // Load and add.
    issue(3'd6, 2'd1, 2'd0, 2'd0, 8'h7F);
    issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h01);
    issue(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
    check("add_r3", {24'b0, result}, 32'h80);
    check("add_carry", {31'b0, carry}, 32'd0);

    // Overflow.
    issue(3'd6, 2'd1, 2'd0, 2'd0, 8'hF0);
    issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h20);
    issue(3'd0, 2'd0, 2'd1, 2'd2, 8'h00);
    check("ovf_result", {24'b0, result}, {24'b0, EXP_OVF});
    check("ovf_carry", {31'b0, carry}, 32'd1);

    // Underflow.
    issue(3'd6, 2'd1, 2'd0, 2'd0, 8'h05);
    issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h09);
    issue(3'd1, 2'd0, 2'd1, 2'd2, 8'h00);
    check("unf_result", {24'b0, result}, {24'b0, EXP_UNF});
    check("unf_carry", {31'b0, carry}, 32'd1);

    // Held handshake: three instructions with instr_valid kept high.
    h_op[0] = 3'd6; h_dst[0] = 2'd0; h_sa[0] = 2'd0; h_sb[0] = 2'd0; h_imm[0] = 8'h31;
    h_op[1] = 3'd6; h_dst[1] = 2'd1; h_sa[1] = 2'd0; h_sb[1] = 2'd0; h_imm[1] = 8'h42;
    h_op[2] = 3'd0; h_dst[2] = 2'd2; h_sa[2] = 2'd0; h_sb[2] = 2'd1; h_imm[2] = 8'h00;
    wait_ready();
    k = 0;
    nd = 0;
    wr_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (rf_wr_en) wr_cnt++;
      if (done) begin
        if (nd < 3) begin
          d_cyc[nd] = cyc;
          ref_op(int'(h_op[nd]), int'(ref_rf[h_sa[nd]]), int'(ref_rf[h_sb[nd]]),
                 int'(h_imm[nd]), er, ec);
          check("held_wr_data", {24'b0, rf_wr_data}, {24'b0, er});
          check("held_wr_addr", {30'b0, rf_wr_addr}, {30'b0, h_dst[nd]});
          $display("held instr %0d: wr R%0d <= %02h (exp %02h)", nd, rf_wr_addr, rf_wr_data, er);
          ref_rf[h_dst[nd]] = er;
        end
        nd++;
      end
      if (instr_ready && k < 3) begin
        instr_valid = 1'b1;
        instr_op    = h_op[k];
        instr_dst   = h_dst[k];
        instr_srca  = h_sa[k];
        instr_srcb  = h_sb[k];
        instr_imm   = h_imm[k];
        hs_cyc[k]   = cyc;
        k++;
      end else if (!instr_ready && k == 3) begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("held_done_count", nd, 3);
    check("held_wr_en_cycles", wr_cnt, 3);
    if (nd >= 3) begin
      for (int j = 0; j < 3; j++) check("held_latency", d_cyc[j] - hs_cyc[j], 3);
      for (int j = 0; j < 2; j++) check("held_spacing", d_cyc[j + 1] - d_cyc[j], 4);
    end
    check("held_r2", {24'b0, rf_mem[2]}, 32'h73);

    // Random instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(7, 0)), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) check("rf_contents", {24'b0, rf_mem[i]}, {24'b0, ref_rf[i]});

    // Reset during EXEC of ADD R2: no write may occur.
    issue(3'd6, 2'd0, 2'd0, 2'd0, 8'h11);
    issue(3'd6, 2'd1, 2'd0, 2'd0, 8'h22);
    issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h5A);
    wait_ready();
    instr_valid = 1'b1;
    instr_op    = 3'd0;
    instr_dst   = 2'd2;
    instr_srca  = 2'd0;
    instr_srcb  = 2'd1;
    instr_imm   = 8'h00;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", {31'b0, rf_wr_en}, 32'd0);
    check("abort_ready", {31'b0, instr_ready}, 32'd0);
    wr_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rf_wr_en) wr_cnt++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rf_wr_en) wr_cnt++;
    end
    check("abort_no_write", wr_cnt, 0);
    check("abort_ready_after", {31'b0, instr_ready}, 32'd1);
    check("abort_r2_kept", {24'b0, rf_mem[2]}, {24'b0, ref_rf[2]});
    $display("abort: R2=%02h (exp %02h)", rf_mem[2], ref_rf[2]);
    issue(3'd6, 2'd3, 2'd0, 2'd0, 8'hA5);
    check("post_abort_ldi", {24'b0, rf_mem[3]}, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
